// File: rtl/rtr_op_ctrl_credit.sv
// Router output-port controller: per-VC credit counters, VC allocation tracking, sticky errors and a registered link stage.
// Optional link sleep/wake power management is enabled by defining RTR_OP_CTRL_LINK_PM_EN.
module rtr_op_ctrl_credit #(
  parameter int num_vcs         = 4,
  parameter int credits_per_vc  = 8,
  parameter int flit_data_width = 64,
  parameter int elig_mask       = 0,
  parameter int credit_bypass   = 1,
  parameter int idle_cycles     = 16,
  localparam int vc_idx_width   = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int cnt_width      = $clog2(credits_per_vc + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           credit_valid_in,
  input  logic [vc_idx_width-1:0]        credit_vc_in,
  input  logic                           flit_valid_in,
  input  logic                           flit_head_in,
  input  logic                           flit_tail_in,
  input  logic [num_vcs-1:0]             flit_sel_in_ovc,
  input  logic [flit_data_width-1:0]     flit_data_in,
  input  logic                           wake_req_in,
  output logic                           channel_valid_out,
  output logic                           channel_head_out,
  output logic                           channel_tail_out,
  output logic [vc_idx_width-1:0]        channel_vc_out,
  output logic [flit_data_width-1:0]     channel_data_out,
  output logic [num_vcs-1:0]             elig_out_ovc,
  output logic [num_vcs-1:0]             empty_out_ovc,
  output logic [num_vcs-1:0]             almost_full_out_ovc,
  output logic [num_vcs-1:0]             full_out_ovc,
  output logic [num_vcs*cnt_width-1:0]   credits_out,
  output logic                           link_sleep_out,
  output logic [2:0]                     error_out
);

  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [cnt_width-1:0] cnt_full = cnt_width'(credits_per_vc);
  localparam logic [cnt_width:0]   eff_full = (cnt_width + 1)'(credits_per_vc);
  localparam logic [cnt_width:0]   eff_one  = (cnt_width + 1)'(1);

  logic [cnt_width-1:0]       cnt_q [num_vcs];
  logic [cnt_width-1:0]       cnt_d [num_vcs];
  logic [num_vcs-1:0]         alloc_q, alloc_d;
  logic [num_vcs-1:0]         credit_on, flit_on, unf, ovf;
  logic [num_vcs-1:0]         empty_raw, af_raw, full_raw, elig_raw;
  logic [cnt_width:0]         eff;
  logic [2:0]                 err_q, err_d;
  logic                       proto_err;
  logic                       pm_mask, pm_flit_err;
  logic [vc_idx_width-1:0]    vc_enc;
  logic                       ch_valid_q, ch_head_q, ch_tail_q;
  logic [vc_idx_width-1:0]    ch_vc_q;
  logic [flit_data_width-1:0] ch_data_q;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    flit_on  = flit_valid_in ? flit_sel_in_ovc : '0;
    vc_enc   = '0;
    eff      = '0;
    for (int v = 0; v < num_vcs; v++) begin
      credit_on[v] = credit_valid_in && (int'(credit_vc_in) == v);
      cnt_d[v]     = cnt_q[v];
      unf[v]       = 1'b0;
      ovf[v]       = 1'b0;
      // A flit and a credit on the same VC cancel out and cannot fault.
      case ({flit_on[v], credit_on[v]})
        2'b10:   if (cnt_q[v] == '0) unf[v] = 1'b1; else cnt_d[v] = cnt_q[v] - cnt_one;
        2'b01:   if (cnt_q[v] == cnt_full) ovf[v] = 1'b1; else cnt_d[v] = cnt_q[v] + cnt_one;
        default: ;
      endcase
      eff          = {1'b0, cnt_q[v]} + {{cnt_width{1'b0}}, (credit_bypass != 0) && credit_on[v]};
      empty_raw[v] = (eff == eff_full);
      af_raw[v]    = (eff == eff_one);
      full_raw[v]  = (eff == '0);
      alloc_d[v]   = flit_on[v] ? ~flit_tail_in : alloc_q[v];
    end
    for (int v = num_vcs - 1; v >= 0; v--) begin
      if (flit_sel_in_ovc[v]) vc_enc = vc_idx_width'(v);
    end
    elig_raw = ~alloc_d;
    if (elig_mask >= 1) elig_raw = elig_raw & ~full_raw;
    if (elig_mask >= 2) elig_raw = elig_raw & empty_raw;
    proto_err = pm_flit_err ||
                (flit_valid_in && (!$onehot(flit_sel_in_ovc) ||
                 (flit_head_in ? |(flit_on & alloc_q) : |(flit_on & ~alloc_q))));
    err_d = err_q | {|unf, |ovf, proto_err};
  end

`ifdef RTR_OP_CTRL_LINK_PM_EN
  typedef enum logic [1:0] {PM_ACTIVE, PM_SLEEP, PM_WAKE} pm_state_e;
  localparam int idle_width = $clog2(idle_cycles + 1);
  localparam logic [idle_width-1:0] idle_last = idle_width'(idle_cycles - 1);

  pm_state_e             state_q, state_d;
  logic [idle_width-1:0] idle_q, idle_d;
  logic                  link_idle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PM_ACTIVE;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    link_idle = !flit_valid_in && !credit_valid_in && (alloc_q == '0);
    for (int v = 0; v < num_vcs; v++) begin
      if (cnt_q[v] != cnt_full) link_idle = 1'b0;
    end
    state_d = state_q;
    idle_d  = '0;
    case (state_q)
      PM_ACTIVE: if (link_idle) begin
        if (idle_q == idle_last) state_d = PM_SLEEP;
        else                     idle_d  = idle_q + idle_width'(1);
      end
      PM_SLEEP:  if (wake_req_in) state_d = PM_WAKE;
      default:   state_d = PM_ACTIVE;
    endcase
  end

  always_comb begin
    pm_mask        = (state_q != PM_ACTIVE);
    link_sleep_out = (state_q == PM_SLEEP);
    pm_flit_err    = pm_mask && flit_valid_in;
  end
`else
  logic unused_wake;
  assign unused_wake    = wake_req_in;
  assign pm_mask        = 1'b0;
  assign pm_flit_err    = 1'b0;
  assign link_sleep_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the per-VC counter array is reset explicitly; it holds live credit state, not scratch data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) cnt_q[v] <= cnt_full;
      alloc_q    <= '0;
      err_q      <= '0;
      ch_valid_q <= 1'b0;
      ch_head_q  <= 1'b0;
      ch_tail_q  <= 1'b0;
      ch_vc_q    <= '0;
      ch_data_q  <= '0;
    end else begin
      for (int v = 0; v < num_vcs; v++) cnt_q[v] <= cnt_d[v];
      alloc_q    <= alloc_d;
      err_q      <= err_d;
      ch_valid_q <= flit_valid_in;
      if (flit_valid_in) begin
        ch_head_q <= flit_head_in;
        ch_tail_q <= flit_tail_in;
        ch_vc_q   <= vc_enc;
        ch_data_q <= flit_data_in;
      end
    end
  end

  for (genvar v = 0; v < num_vcs; v++) begin : g_credits
    assign credits_out[(num_vcs-1-v)*cnt_width +: cnt_width] = cnt_q[v];
  end

  assign channel_valid_out   = ch_valid_q;
  assign channel_head_out    = ch_head_q;
  assign channel_tail_out    = ch_tail_q;
  assign channel_vc_out      = ch_vc_q;
  assign channel_data_out    = ch_data_q;
  assign elig_out_ovc        = pm_mask ? '0 : elig_raw;
  assign full_out_ovc        = pm_mask ? '1 : full_raw;
  assign empty_out_ovc       = empty_raw;
  assign almost_full_out_ovc = af_raw;
  assign error_out           = err_q;

endmodule

// File: tb/tb_rtr_op_ctrl_credit.sv
// Directed self-checking bench for rtr_op_ctrl_credit with default parameters (4 VCs, 8 credits each).
module tb_rtr_op_ctrl_credit;

  logic        clk = 1'b0;
  logic        reset;
  logic        credit_valid_in;
  logic [1:0]  credit_vc_in;
  logic        flit_valid_in, flit_head_in, flit_tail_in;
  logic [3:0]  flit_sel_in_ovc;
  logic [63:0] flit_data_in;
  logic        wake_req_in;
  logic        channel_valid_out, channel_head_out, channel_tail_out;
  logic [1:0]  channel_vc_out;
  logic [63:0] channel_data_out;
  logic [3:0]  elig_out_ovc, empty_out_ovc, almost_full_out_ovc, full_out_ovc;
  logic [15:0] credits_out;
  logic        link_sleep_out;
  logic [2:0]  error_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtr_op_ctrl_credit dut (
    .clk                 (clk),
    .reset               (reset),
    .credit_valid_in     (credit_valid_in),
    .credit_vc_in        (credit_vc_in),
    .flit_valid_in       (flit_valid_in),
    .flit_head_in        (flit_head_in),
    .flit_tail_in        (flit_tail_in),
    .flit_sel_in_ovc     (flit_sel_in_ovc),
    .flit_data_in        (flit_data_in),
    .wake_req_in         (wake_req_in),
    .channel_valid_out   (channel_valid_out),
    .channel_head_out    (channel_head_out),
    .channel_tail_out    (channel_tail_out),
    .channel_vc_out      (channel_vc_out),
    .channel_data_out    (channel_data_out),
    .elig_out_ovc        (elig_out_ovc),
    .empty_out_ovc       (empty_out_ovc),
    .almost_full_out_ovc (almost_full_out_ovc),
    .full_out_ovc        (full_out_ovc),
    .credits_out         (credits_out),
    .link_sleep_out      (link_sleep_out),
    .error_out           (error_out)
  );

  task automatic idle_inputs();
    credit_valid_in = 1'b0;
    credit_vc_in    = '0;
    flit_valid_in   = 1'b0;
    flit_head_in    = 1'b0;
    flit_tail_in    = 1'b0;
    flit_sel_in_ovc = '0;
    flit_data_in    = '0;
    wake_req_in     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input logic [3:0] sel, input logic head, input logic tail, input logic [63:0] data);
    flit_valid_in   = 1'b1;
    flit_sel_in_ovc = sel;
    flit_head_in    = head;
    flit_tail_in    = tail;
    flit_data_in    = data;
  endtask

  task automatic send(input logic [3:0] sel, input logic head, input logic tail, input logic [63:0] data);
    set_flit(sel, head, tail, data);
    step();
    idle_inputs();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    send(4'b0001, 1'b1, 1'b0, 64'hFF);
    credit_valid_in = 1'b1; credit_vc_in = 2'd3;
    step();
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++; if (credits_out !== 16'h8888) begin failures++; $display("FAIL reset_credits got=%h exp=%h", credits_out, 16'h8888); end
    checks++; if (empty_out_ovc !== 4'hF) begin failures++; $display("FAIL reset_empty got=%b exp=1111", empty_out_ovc); end
    checks++; if (full_out_ovc !== 4'h0 || almost_full_out_ovc !== 4'h0) begin failures++; $display("FAIL reset_full got=%b/%b exp=0000/0000", full_out_ovc, almost_full_out_ovc); end
    checks++; if (elig_out_ovc !== 4'hF) begin failures++; $display("FAIL reset_elig got=%b exp=1111", elig_out_ovc); end
    checks++; if ({channel_valid_out, channel_head_out, channel_tail_out, channel_vc_out} !== 5'b0 || channel_data_out !== 64'h0) begin
      failures++; $display("FAIL reset_channel got=%b%b%b vc=%0d data=%h exp=all zero", channel_valid_out, channel_head_out, channel_tail_out, channel_vc_out, channel_data_out); end
    checks++; if (error_out !== 3'b000 || link_sleep_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b sleep=%b exp=000 sleep=0", error_out, link_sleep_out); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_latency();
    apply_reset();
    set_flit(4'b0100, 1'b1, 1'b1, 64'hA5);
    #1;
    checks++; if (elig_out_ovc !== 4'hF) begin failures++; $display("FAIL lat_elig_same_cycle got=%b exp=1111", elig_out_ovc); end
    step();
    idle_inputs();
    #1;
    checks++; if (channel_valid_out !== 1'b1 || channel_vc_out !== 2'd2 || channel_data_out !== 64'hA5 || channel_head_out !== 1'b1 || channel_tail_out !== 1'b1) begin
      failures++; $display("FAIL lat_channel got=v%b h%b t%b vc=%0d data=%h exp=v1 h1 t1 vc=2 data=a5", channel_valid_out, channel_head_out, channel_tail_out, channel_vc_out, channel_data_out); end
    checks++; if (credits_out !== 16'h8878) begin failures++; $display("FAIL lat_credits got=%h exp=8878", credits_out); end
    checks++; if (empty_out_ovc !== 4'b1011) begin failures++; $display("FAIL lat_empty got=%b exp=1011", empty_out_ovc); end
    step();
    checks++; if (channel_valid_out !== 1'b0 || channel_vc_out !== 2'd2 || channel_data_out !== 64'hA5) begin
      failures++; $display("FAIL lat_hold got=v%b vc=%0d data=%h exp=v0 vc=2 data=a5", channel_valid_out, channel_vc_out, channel_data_out); end
    credit_valid_in = 1'b1; credit_vc_in = 2'd2;
    #1;
    checks++; if (empty_out_ovc !== 4'hF || credits_out !== 16'h8878) begin failures++; $display("FAIL lat_bypass got=%b/%h exp=1111/8878", empty_out_ovc, credits_out); end
    step();
    idle_inputs();
    #1;
    checks++; if (credits_out !== 16'h8888 || error_out !== 3'b000) begin failures++; $display("FAIL lat_return got=%h err=%b exp=8888 err=000", credits_out, error_out); end
  endtask

  task automatic test_exhaust();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send(4'b0010, (i == 0), (i == 7), 64'(i));
      if (i == 0) begin
        checks++; if (elig_out_ovc[1] !== 1'b0) begin failures++; $display("FAIL exh_alloc got=%b exp=0", elig_out_ovc[1]); end
      end
      if (i == 6) begin
        checks++; if (almost_full_out_ovc[1] !== 1'b1 || full_out_ovc[1] !== 1'b0 || credits_out !== 16'h8188) begin
          failures++; $display("FAIL exh_almost got=af%b f%b %h exp=af1 f0 8188", almost_full_out_ovc[1], full_out_ovc[1], credits_out); end
      end
    end
    checks++; if (full_out_ovc !== 4'b0010 || almost_full_out_ovc[1] !== 1'b0 || credits_out !== 16'h8088) begin
      failures++; $display("FAIL exh_full got=f%b af%b %h exp=f0010 af0 8088", full_out_ovc, almost_full_out_ovc[1], credits_out); end
    checks++; if (elig_out_ovc !== 4'hF || error_out !== 3'b000) begin failures++; $display("FAIL exh_freed got=%b err=%b exp=1111 err=000", elig_out_ovc, error_out); end
    credit_valid_in = 1'b1; credit_vc_in = 2'd1;
    #1;
    checks++; if (full_out_ovc[1] !== 1'b0 || almost_full_out_ovc[1] !== 1'b1) begin failures++; $display("FAIL exh_bypass got=f%b af%b exp=f0 af1", full_out_ovc[1], almost_full_out_ovc[1]); end
    idle_inputs();
    #1;
    send(4'b0010, 1'b1, 1'b1, 64'h9);
    checks++; if (error_out !== 3'b100 || credits_out !== 16'h8088) begin failures++; $display("FAIL exh_underflow got=%b %h exp=100 8088", error_out, credits_out); end
    checks++; if (channel_valid_out !== 1'b1 || channel_data_out !== 64'h9) begin failures++; $display("FAIL exh_forward got=v%b %h exp=v1 9", channel_valid_out, channel_data_out); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 5; i++) send(4'b0001, (i == 0), 1'b0, 64'(i));
    checks++; if (credits_out !== 16'h3888) begin failures++; $display("FAIL sim_count got=%h exp=3888", credits_out); end
    set_flit(4'b0001, 1'b0, 1'b0, 64'h55);
    credit_valid_in = 1'b1; credit_vc_in = 2'd0;
    step();
    idle_inputs();
    #1;
    checks++; if (credits_out !== 16'h3888 || error_out !== 3'b000) begin failures++; $display("FAIL sim_cancel got=%h err=%b exp=3888 err=000", credits_out, error_out); end
    credit_valid_in = 1'b1; credit_vc_in = 2'd3;
    step();
    idle_inputs();
    #1;
    checks++; if (error_out !== 3'b010 || credits_out !== 16'h3888) begin failures++; $display("FAIL sim_overflow got=%b %h exp=010 3888", error_out, credits_out); end
    step();
    step();
    checks++; if (error_out !== 3'b010) begin failures++; $display("FAIL sim_sticky got=%b exp=010", error_out); end
  endtask

  task automatic test_protocol();
    apply_reset();
    send(4'b0001, 1'b1, 1'b0, 64'h1);
    checks++; if (error_out !== 3'b000) begin failures++; $display("FAIL proto_first_head got=%b exp=000", error_out); end
    send(4'b0001, 1'b1, 1'b0, 64'h2);
    checks++; if (error_out !== 3'b001) begin failures++; $display("FAIL proto_double_head got=%b exp=001", error_out); end
    apply_reset();
    send(4'b0010, 1'b0, 1'b0, 64'h3);
    checks++; if (error_out !== 3'b001) begin failures++; $display("FAIL proto_body_idle got=%b exp=001", error_out); end
    apply_reset();
    send(4'b0011, 1'b1, 1'b1, 64'h4);
    checks++; if (error_out !== 3'b001) begin failures++; $display("FAIL proto_onehot got=%b exp=001", error_out); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_flit(4'b0001, 1'b1, 1'b1, 64'h1111);
    step();
    checks++; if (channel_valid_out !== 1'b1 || channel_vc_out !== 2'd0 || channel_data_out !== 64'h1111) begin
      failures++; $display("FAIL b2b_0 got=v%b vc=%0d %h exp=v1 vc=0 1111", channel_valid_out, channel_vc_out, channel_data_out); end
    set_flit(4'b1000, 1'b1, 1'b1, 64'h2222);
    step();
    checks++; if (channel_valid_out !== 1'b1 || channel_vc_out !== 2'd3 || channel_data_out !== 64'h2222) begin
      failures++; $display("FAIL b2b_1 got=v%b vc=%0d %h exp=v1 vc=3 2222", channel_valid_out, channel_vc_out, channel_data_out); end
    set_flit(4'b0100, 1'b1, 1'b0, 64'h3333);
    step();
    idle_inputs();
    #1;
    checks++; if (channel_vc_out !== 2'd2 || channel_data_out !== 64'h3333 || channel_head_out !== 1'b1 || channel_tail_out !== 1'b0) begin
      failures++; $display("FAIL b2b_2 got=vc=%0d %h h%b t%b exp=vc=2 3333 h1 t0", channel_vc_out, channel_data_out, channel_head_out, channel_tail_out); end
    checks++; if (credits_out !== 16'h7877 || elig_out_ovc !== 4'b1011 || error_out !== 3'b000) begin
      failures++; $display("FAIL b2b_state got=%h elig=%b err=%b exp=7877 elig=1011 err=000", credits_out, elig_out_ovc, error_out); end
  endtask

  task automatic test_link_pm();
    apply_reset();
`ifdef RTR_OP_CTRL_LINK_PM_EN
    for (int i = 0; i < 15; i++) step();
    checks++; if (link_sleep_out !== 1'b0 || elig_out_ovc !== 4'hF) begin failures++; $display("FAIL pm_early got=%b elig=%b exp=0 elig=1111", link_sleep_out, elig_out_ovc); end
    step();
    checks++; if (link_sleep_out !== 1'b1 || elig_out_ovc !== 4'h0 || full_out_ovc !== 4'hF) begin
      failures++; $display("FAIL pm_sleep got=%b elig=%b full=%b exp=1 0000 1111", link_sleep_out, elig_out_ovc, full_out_ovc); end
    wake_req_in = 1'b1;
    step();
    wake_req_in = 1'b0;
    #1;
    checks++; if (link_sleep_out !== 1'b0 || elig_out_ovc !== 4'h0) begin failures++; $display("FAIL pm_wake got=%b elig=%b exp=0 0000", link_sleep_out, elig_out_ovc); end
    step();
    checks++; if (link_sleep_out !== 1'b0 || elig_out_ovc !== 4'hF || full_out_ovc !== 4'h0) begin
      failures++; $display("FAIL pm_active got=%b elig=%b full=%b exp=0 1111 0000", link_sleep_out, elig_out_ovc, full_out_ovc); end
`else
    for (int i = 0; i < 20; i++) step();
    wake_req_in = 1'b1;
    step();
    wake_req_in = 1'b0;
    #1;
    checks++; if (link_sleep_out !== 1'b0 || elig_out_ovc !== 4'hF || full_out_ovc !== 4'h0) begin
      failures++; $display("FAIL pm_absent got=%b elig=%b full=%b exp=0 1111 0000", link_sleep_out, elig_out_ovc, full_out_ovc); end
`endif
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    test_reset();
    test_latency();
    test_exhaust();
    test_simultaneous();
    test_protocol();
    test_back_to_back();
    test_link_pm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
